// File: rtl/freq_meas_pkg.sv
// Shared state type and default parameters for the gated frequency/duty
// measurement sequencer.
package freq_meas_pkg;

    localparam int CNT_W_DEFAULT       = 32;
    localparam int CH_NUM_DEFAULT      = 2;
    localparam int TIMEOUT_CYC_DEFAULT = 200_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } meas_state_e;

endpackage

// File: rtl/freq_meas_sched_edge_sync.sv
// Brings one asynchronous wave_in bit into pll_clk and flags its rising edges;
// level is the delayed copy so it lines up with the rise flag.
module edge_sync
    import freq_meas_pkg::*;
(
    input  logic pll_clk,
    input  logic sys_rst_n,
    input  logic wave_in,
    output logic rise,
    output logic level
);

    logic sync1_r;
    logic sync2_r;
    logic dly_r;

    // Two-stage synchronizer followed by the edge register.
    always_ff @(posedge pll_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            dly_r   <= 1'b0;
        end else begin
            sync1_r <= wave_in;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
        end
    end

    assign rise  = sync2_r & ~dly_r;
    assign level = dly_r;

endmodule

// File: rtl/freq_meas_sched.sv
// Round-robin scheduler for equal-precision N-period measurements on the
// wave_in channels, with per-channel timeout and a valid/ready result port.
module freq_meas_sched
    import freq_meas_pkg::*;
#(
    parameter int  CNT_W       = CNT_W_DEFAULT,
    parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int  CH_NUM      = CH_NUM_DEFAULT,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              pll_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic [15:0]       n_periods,
    input  logic [CH_NUM-1:0] wave_in,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic [CNT_W-1:0]  res_ticks,
    output logic [CNT_W-1:0]  res_high,
    output logic              res_timeout
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W:0]    CH_ZERO  = {(CH_W+1){1'b0}};
    localparam logic [CH_W:0]    CH_ONE   = {{CH_W{1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_ONES) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Lowest enabled channel with index >= from; MSB of the result is "found".
    function automatic logic [CH_W:0] pick_ch(input logic [CH_NUM-1:0] mask,
                                              input logic [CH_W:0]     from);
        logic [CH_W:0] r;
        r = CH_ZERO;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = {1'b1, CH_W'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [CH_NUM-1:0] rise_s;
    logic [CH_NUM-1:0] level_s;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_sync
        edge_sync u_edge_sync (
            .pll_clk   (pll_clk),
            .sys_rst_n (sys_rst_n),
            .wave_in   (wave_in[g]),
            .rise      (rise_s[g]),
            .level     (level_s[g])
        );
    end

    meas_state_e       state_r, state_nx;
    logic [CH_NUM-1:0] ch_en_r, ch_en_nx;
    logic [15:0]       n_r, n_nx;
    logic [CH_W-1:0]   cur_ch_r, cur_ch_nx;
    logic [CNT_W-1:0]  tmo_r, tmo_nx;
    logic [CNT_W-1:0]  ticks_r, ticks_nx;
    logic [CNT_W-1:0]  high_r, high_nx;
    logic [15:0]       edges_r, edges_nx;
    logic              busy_r, busy_nx;
    logic              res_valid_r, res_valid_nx;
    logic [CH_W-1:0]   res_ch_r, res_ch_nx;
    logic [CNT_W-1:0]  res_ticks_r, res_ticks_nx;
    logic [CNT_W-1:0]  res_high_r, res_high_nx;
    logic              res_timeout_r, res_timeout_nx;

    logic              sel_rise_s;
    logic              sel_level_s;
    logic [CH_W:0]     pick_s;
    logic              go_arm_s;
    logic              go_done_s;
    logic              done_tmo_s;

    assign sel_rise_s  = rise_s[cur_ch_r];
    assign sel_level_s = level_s[cur_ch_r];

    // Next-state, counter and result computation for the scheduler.
    always_comb begin
        state_nx       = state_r;
        ch_en_nx       = ch_en_r;
        n_nx           = n_r;
        cur_ch_nx      = cur_ch_r;
        tmo_nx         = tmo_r;
        ticks_nx       = ticks_r;
        high_nx        = high_r;
        edges_nx       = edges_r;
        res_valid_nx   = res_valid_r;
        res_ch_nx      = res_ch_r;
        res_ticks_nx   = res_ticks_r;
        res_high_nx    = res_high_r;
        res_timeout_nx = res_timeout_r;
        pick_s         = CH_ZERO;
        go_arm_s       = 1'b0;
        go_done_s      = 1'b0;
        done_tmo_s     = 1'b0;

        if (stop) begin
            state_nx     = ST_IDLE;
            res_valid_nx = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (ch_en != {CH_NUM{1'b0}})) begin
                        ch_en_nx = ch_en;
                        n_nx     = (n_periods == 16'd0) ? 16'd1 : n_periods;
                        pick_s   = pick_ch(ch_en, CH_ZERO);
                        go_arm_s = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    tmo_nx = sat_inc(tmo_r);
                    // A rise in the ARM entry cycle (tmo still 0) is not taken.
                    if (tmo_r >= TMO_LAST) begin
                        go_done_s  = 1'b1;
                        done_tmo_s = 1'b1;
                    end else if (sel_rise_s && (tmo_r != CNT_ZERO)) begin
                        state_nx = ST_MEAS;
                    end else begin
                        state_nx = ST_ARM;
                    end
                end
                ST_MEAS: begin
                    tmo_nx   = sat_inc(tmo_r);
                    ticks_nx = sat_inc(ticks_r);
                    if (sel_level_s) begin
                        high_nx = sat_inc(high_r);
                    end else begin
                        high_nx = high_r;
                    end
                    if (sel_rise_s) begin
                        edges_nx = edges_r + 16'd1;
                    end else begin
                        edges_nx = edges_r;
                    end
                    if (sel_rise_s && ((edges_r + 16'd1) == n_r)) begin
                        go_done_s = 1'b1;
                    end else if (tmo_r >= TMO_LAST) begin
                        go_done_s  = 1'b1;
                        done_tmo_s = 1'b1;
                    end else begin
                        state_nx = ST_MEAS;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_nx = 1'b0;
                        pick_s       = pick_ch(ch_en_r, {1'b0, cur_ch_r} + CH_ONE);
                        if (pick_s[CH_W]) begin
                            go_arm_s = 1'b1;
                        end else if (cont) begin
                            pick_s   = pick_ch(ch_en_r, CH_ZERO);
                            go_arm_s = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase

            if (go_done_s) begin
                state_nx       = ST_DONE;
                res_valid_nx   = 1'b1;
                res_ch_nx      = cur_ch_r;
                res_timeout_nx = done_tmo_s;
                res_ticks_nx   = done_tmo_s ? CNT_ZERO : ticks_nx;
                res_high_nx    = done_tmo_s ? CNT_ZERO : high_nx;
            end else if (go_arm_s) begin
                state_nx  = ST_ARM;
                cur_ch_nx = pick_s[CH_W-1:0];
                tmo_nx    = CNT_ZERO;
                ticks_nx  = CNT_ZERO;
                high_nx   = CNT_ZERO;
                edges_nx  = 16'd0;
            end else begin
                cur_ch_nx = cur_ch_r;
            end
        end

        busy_nx = (state_nx != ST_IDLE);
    end

    // State, counter and registered-output update.
    always_ff @(posedge pll_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r       <= ST_IDLE;
            ch_en_r       <= {CH_NUM{1'b0}};
            n_r           <= 16'd1;
            cur_ch_r      <= {CH_W{1'b0}};
            tmo_r         <= CNT_ZERO;
            ticks_r       <= CNT_ZERO;
            high_r        <= CNT_ZERO;
            edges_r       <= 16'd0;
            busy_r        <= 1'b0;
            res_valid_r   <= 1'b0;
            res_ch_r      <= {CH_W{1'b0}};
            res_ticks_r   <= CNT_ZERO;
            res_high_r    <= CNT_ZERO;
            res_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nx;
            ch_en_r       <= ch_en_nx;
            n_r           <= n_nx;
            cur_ch_r      <= cur_ch_nx;
            tmo_r         <= tmo_nx;
            ticks_r       <= ticks_nx;
            high_r        <= high_nx;
            edges_r       <= edges_nx;
            busy_r        <= busy_nx;
            res_valid_r   <= res_valid_nx;
            res_ch_r      <= res_ch_nx;
            res_ticks_r   <= res_ticks_nx;
            res_high_r    <= res_high_nx;
            res_timeout_r <= res_timeout_nx;
        end
    end

    assign busy        = busy_r;
    assign res_valid   = res_valid_r;
    assign res_ch      = res_ch_r;
    assign res_ticks   = res_ticks_r;
    assign res_high    = res_high_r;
    assign res_timeout = res_timeout_r;

endmodule

// File: tb/tb_freq_meas_sched.sv
// Directed plus randomized bench for freq_meas_sched; expected counts come from
// the generated waveform parameters (N periods of P cycles, H cycles high each).
module tb_freq_meas_sched;

    logic        pll_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic [1:0]  ch_en = 2'b00;
    logic [15:0] n_periods = 16'd0;
    logic [1:0]  wave_in;
    logic        busy;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_ch;
    logic [31:0] res_ticks;
    logic [31:0] res_high;
    logic        res_timeout;

    logic        t_start = 1'b0;
    logic        t_res_ready = 1'b0;
    logic        t_busy;
    logic        t_res_valid;
    logic        t_res_ch;
    logic [31:0] t_res_ticks;
    logic [31:0] t_res_high;
    logic        t_res_timeout;

    int vectors = 0;
    int miscompares = 0;
    int per [2] = '{0, 0};
    int hi  [2] = '{0, 0};
    logic wv0 = 1'b0;
    logic wv1 = 1'b0;

    assign wave_in = {wv1, wv0};

    always #5 pll_clk = ~pll_clk;

    freq_meas_sched dut (
        .pll_clk(pll_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .cont(cont), .ch_en(ch_en), .n_periods(n_periods), .wave_in(wave_in),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_ticks(res_ticks), .res_high(res_high), .res_timeout(res_timeout)
    );

    freq_meas_sched #(.TIMEOUT_CYC(1000)) dut_tmo (
        .pll_clk(pll_clk), .sys_rst_n(sys_rst_n), .start(t_start), .stop(1'b0),
        .cont(1'b0), .ch_en(2'b01), .n_periods(16'd1), .wave_in(2'b00),
        .busy(t_busy), .res_valid(t_res_valid), .res_ready(t_res_ready), .res_ch(t_res_ch),
        .res_ticks(t_res_ticks), .res_high(t_res_high), .res_timeout(t_res_timeout)
    );

    // Square-wave generators; parameters are re-read at the start of every period.
    initial begin
        forever begin
            if (hi[0] == 0) begin
                wv0 = 1'b0;
                @(negedge pll_clk);
            end else begin
                int p, h;
                p = per[0];
                h = hi[0];
                wv0 = 1'b1;
                repeat (h) @(negedge pll_clk);
                wv0 = 1'b0;
                repeat (p - h) @(negedge pll_clk);
            end
        end
    end

    initial begin
        forever begin
            if (hi[1] == 0) begin
                wv1 = 1'b0;
                @(negedge pll_clk);
            end else begin
                int p, h;
                p = per[1];
                h = hi[1];
                wv1 = 1'b1;
                repeat (h) @(negedge pll_clk);
                wv1 = 1'b0;
                repeat (p - h) @(negedge pll_clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_wave(input int ch, input int p, input int h);
        per[ch] = p;
        hi[ch]  = h;
        repeat (20) @(negedge pll_clk);
    endtask

    task automatic do_start(input logic [1:0] mask, input logic [15:0] n, input logic c);
        @(negedge pll_clk);
        ch_en = mask;
        n_periods = n;
        cont = c;
        start = 1'b1;
        @(negedge pll_clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge pll_clk);
            ok = res_valid;
        end
    endtask

    task automatic take(input int ch, input int ticks, input int high, input int budget,
                        input int hold, input string tag);
        bit ok;
        wait_valid(budget, ok);
        chk({tag, " valid"}, 64'(ok), 64'd1);
        chk({tag, " ch"}, 64'(res_ch), 64'(ch));
        chk({tag, " ticks"}, 64'(res_ticks), 64'(ticks));
        chk({tag, " high"}, 64'(res_high), 64'(high));
        chk({tag, " timeout"}, 64'(res_timeout), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge pll_clk);
            chk({tag, " hold valid"}, 64'(res_valid), 64'd1);
            chk({tag, " hold ticks"}, 64'(res_ticks), 64'(ticks));
            chk({tag, " hold high"}, 64'(res_high), 64'(high));
        end
        res_ready = 1'b1;
        @(negedge pll_clk);
        res_ready = 1'b0;
        chk({tag, " valid drop"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        bit ok;
        int cyc;

        // Reset state of both instances.
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(res_valid), 64'd0);
        chk("rst ch", 64'(res_ch), 64'd0);
        chk("rst ticks", 64'(res_ticks), 64'd0);
        chk("rst high", 64'(res_high), 64'd0);
        chk("rst timeout", 64'(res_timeout), 64'd0);
        chk("rst tmo busy", 64'(t_busy), 64'd0);
        repeat (3) @(negedge pll_clk);
        sys_rst_n = 1'b1;

        // Single channel, N=4, 200-cycle period at 50% duty.
        set_wave(0, 200, 100);
        set_wave(1, 50, 10);
        do_start(2'b01, 16'd4, 1'b0);
        chk("A busy", 64'(busy), 64'd1);
        take(0, 800, 400, 1500, 0, "A");
        chk("A idle", 64'(busy), 64'd0);

        // start with an empty mask is ignored.
        do_start(2'b00, 16'd4, 1'b0);
        chk("empty mask busy", 64'(busy), 64'd0);

        // Both channels, N=10; first result held 50 cycles before acceptance.
        do_start(2'b11, 16'd10, 1'b0);
        take(0, 2000, 1000, 2600, 50, "B0");
        take(1, 500, 100, 800, 0, "B1");
        chk("B idle", 64'(busy), 64'd0);

        // n_periods=0 behaves as a single period.
        set_wave(0, 200, 70);
        do_start(2'b01, 16'd0, 1'b0);
        take(0, 200, 70, 700, 0, "N0");

        // Randomized passes against the period/duty model.
        for (int it = 0; it < 4; it++) begin
            int m, n, ne;
            int p [2];
            int h [2];
            for (int c = 0; c < 2; c++) begin
                p[c] = int'($urandom_range(200, 8));
                h[c] = int'($urandom_range(p[c] - 1, 1));
            end
            per[0] = p[0];
            hi[0] = h[0];
            set_wave(1, p[1], h[1]);
            m = int'($urandom_range(3, 1));
            n = int'($urandom_range(8, 0));
            ne = (n == 0) ? 1 : n;
            do_start(2'(m), 16'(n), 1'b0);
            for (int c = 0; c < 2; c++) begin
                if (m[c]) begin
                    take(c, ne * p[c], ne * h[c], (ne + 2) * p[c] + 50, 0, "rand");
                end
            end
            chk("rand idle", 64'(busy), 64'd0);
        end

        // Continuous mode on ch0 repeats until stop.
        set_wave(0, 100, 30);
        do_start(2'b01, 16'd2, 1'b1);
        for (int r = 0; r < 3; r++) begin
            take(0, 200, 60, 500, 0, "cont");
        end
        repeat (30) @(negedge pll_clk);
        chk("cont running", 64'(busy), 64'd1);
        stop = 1'b1;
        @(negedge pll_clk);
        stop = 1'b0;
        chk("stop busy", 64'(busy), 64'd0);
        chk("stop valid", 64'(res_valid), 64'd0);

        // stop wins over a handshake completing in the same cycle.
        do_start(2'b01, 16'd1, 1'b1);
        wait_valid(400, ok);
        chk("stop+hs valid seen", 64'(ok), 64'd1);
        stop = 1'b1;
        res_ready = 1'b1;
        @(negedge pll_clk);
        stop = 1'b0;
        res_ready = 1'b0;
        chk("stop+hs valid", 64'(res_valid), 64'd0);
        chk("stop+hs busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a measurement.
        set_wave(0, 200, 100);
        do_start(2'b01, 16'd4, 1'b0);
        repeat (400) @(negedge pll_clk);
        chk("pre-rst busy", 64'(busy), 64'd1);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst valid", 64'(res_valid), 64'd0);
        chk("mid rst ticks", 64'(res_ticks), 64'd0);
        chk("mid rst high", 64'(res_high), 64'd0);
        @(negedge pll_clk);
        sys_rst_n = 1'b1;
        do_start(2'b01, 16'd4, 1'b0);
        take(0, 800, 400, 1500, 0, "post rst");

        // Timeout instance: input stuck low, TIMEOUT_CYC=1000.
        @(negedge pll_clk);
        t_start = 1'b1;
        @(negedge pll_clk);
        t_start = 1'b0;
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 1200) begin
            @(negedge pll_clk);
            cyc++;
            ok = t_res_valid;
        end
        chk("tmo latency", 64'(cyc), 64'd1000);
        chk("tmo flag", 64'(t_res_timeout), 64'd1);
        chk("tmo ticks", 64'(t_res_ticks), 64'd0);
        chk("tmo high", 64'(t_res_high), 64'd0);
        chk("tmo ch", 64'(t_res_ch), 64'd0);
        t_res_ready = 1'b1;
        @(negedge pll_clk);
        t_res_ready = 1'b0;
        chk("tmo valid drop", 64'(t_res_valid), 64'd0);
        chk("tmo idle", 64'(t_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
